ex_mdu: RTL



---
 rtl/ex_mdu_pkg.sv | 39 +++
 rtl/ex_mdu_if.sv | 25 ++
 rtl/ex_mdu_div.sv | 60 ++++++
 rtl/ex_mdu.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/ex_mdu_pkg.sv
// Shared encodings for the RV32M multiply/divide unit: func7/func3 constants,
// FSM state encoding and small op-classification helpers.
package ex_mdu_pkg;

  localparam logic [6:0] FUNC7_M = 7'b000_0001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic is_mul_op(input logic [2:0] f3);
    return ~f3[2];
  endfunction

  function automatic logic op1_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic op2_signed(input logic [2:0] f3);
    return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic is_rem_op(input logic [2:0] f3);
    return (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

endpackage

// File: rtl/ex_mdu_if.sv
// Issue/write-back bundle between id_ex/ctrl and the multiply/divide unit.
interface ex_mdu_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] op1_i;
  logic [XLEN-1:0] op2_i;
  logic [4:0]      rd_addr_i;
  logic            flush_i;
  logic            hold_flag_o;
  logic [4:0]      rd_addr_o;
  logic [XLEN-1:0] rd_data_o;
  logic            reg_wen_o;

  modport master (
    output start_i, op_i, op1_i, op2_i, rd_addr_i, flush_i,
    input  hold_flag_o, rd_addr_o, rd_data_o, reg_wen_o
  );

  modport slave (
    input  start_i, op_i, op1_i, op2_i, rd_addr_i, flush_i,
    output hold_flag_o, rd_addr_o, rd_data_o, reg_wen_o
  );
endinterface

// File: rtl/ex_mdu_div.sv
// Restoring divider datapath on unsigned magnitudes, one quotient bit per step.
// The *_nxt_o outputs expose the post-step values so the FSM can finish in the last step.
module ex_mdu_div #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            step_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quot_nxt_o,
  output logic [XLEN-1:0] rem_nxt_o
);

  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvsr_q, dvsr_d;
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   diff;

  // quot_q starts as the dividend; its MSB feeds the partial remainder each step
  assign rem_shift = {rem_q, quot_q[XLEN-1]};
  assign diff      = rem_shift - {1'b0, dvsr_q};

  always_comb begin
    quot_d = quot_q;
    rem_d  = rem_q;
    dvsr_d = dvsr_q;
    if (load_i) begin
      quot_d = dividend_i;
      rem_d  = '0;
      dvsr_d = divisor_i;
    end else if (step_i) begin
      if (!diff[XLEN]) begin
        rem_d  = diff[XLEN-1:0];
        quot_d = {quot_q[XLEN-2:0], 1'b1};
      end else begin
        rem_d  = rem_shift[XLEN-1:0];
        quot_d = {quot_q[XLEN-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quot_q <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
    end else begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dvsr_q <= dvsr_d;
    end
  end

  assign quot_nxt_o = quot_d;
  assign rem_nxt_o  = rem_d;

endmodule

// File: rtl/ex_mdu.sv
// Multi-cycle RV32M unit: FSM, sign handling, shift-add multiplier, divide special cases.
// state | meaning: IDLE wait for op | MUL shift-add | DIV restoring steps | DONE write-back beat
module ex_mdu
  import ex_mdu_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input logic     clk,
  input logic     rst,
  ex_mdu_if.slave mdu
);

  localparam int CW      = $clog2(XLEN + 1);
  localparam int MUL_CNT = XLEN / MUL_STEP;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic              wen_q, wen_d;
  logic [4:0]        waddr_q, waddr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;

  logic              accept;
  logic              sgn1, sgn2;
  logic [XLEN-1:0]   mag1, mag2;
  logic              div_zero, div_ovf;
  logic [2*XLEN-1:0] mul_acc_nxt, mul_prod;
  logic [XLEN-1:0]   mul_res;
  logic              div_load;
  logic [XLEN-1:0]   quot_nxt, rem_nxt, div_res;

  assign accept   = mdu.start_i & ~mdu.flush_i;
  assign sgn1     = op1_signed(mdu.op_i) & mdu.op1_i[XLEN-1];
  assign sgn2     = op2_signed(mdu.op_i) & mdu.op2_i[XLEN-1];
  assign mag1     = sgn1 ? -mdu.op1_i : mdu.op1_i;
  assign mag2     = sgn2 ? -mdu.op2_i : mdu.op2_i;
  assign div_zero = (mdu.op2_i == '0);
  assign div_ovf  = op2_signed(mdu.op_i) & ~is_mul_op(mdu.op_i)
                    & (mdu.op1_i == MIN_NEG) & (mdu.op2_i == '1);

  always_comb begin
    mul_acc_nxt = acc_q;
    for (int j = 0; j < MUL_STEP; j++) begin
      if (mplier_q[j]) mul_acc_nxt = mul_acc_nxt + (mcand_q << j);
    end
  end

  assign mul_prod = neg_res_q ? -mul_acc_nxt : mul_acc_nxt;
  assign mul_res  = (op_q == F3_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];

  ex_mdu_div #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .rst       (rst),
    .load_i    (div_load),
    .step_i    (state_q == ST_DIV),
    .dividend_i(mag1),
    .divisor_i (mag2),
    .quot_nxt_o(quot_nxt),
    .rem_nxt_o (rem_nxt)
  );

  assign div_res = is_rem_op(op_q) ? (neg_rem_q ? -rem_nxt : rem_nxt)
                                   : (neg_res_q ? -quot_nxt : quot_nxt);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    mplier_d  = mplier_q;
    wen_d     = 1'b0;
    waddr_d   = '0;
    wdata_d   = '0;
    div_load  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d      = mdu.op_i;
          rd_d      = mdu.rd_addr_i;
          neg_res_d = sgn1 ^ sgn2;
          neg_rem_d = sgn1;
          if (is_mul_op(mdu.op_i)) begin
            state_d  = ST_MUL;
            cnt_d    = CW'(MUL_CNT);
            mcand_d  = {{XLEN{1'b0}}, mag1};
            mplier_d = mag2;
            acc_d    = '0;
          end else if (div_zero) begin
            state_d = ST_DONE;
            wen_d   = 1'b1;
            waddr_d = mdu.rd_addr_i;
            wdata_d = is_rem_op(mdu.op_i) ? mdu.op1_i : '1;
          end else if (div_ovf) begin
            state_d = ST_DONE;
            wen_d   = 1'b1;
            waddr_d = mdu.rd_addr_i;
            wdata_d = is_rem_op(mdu.op_i) ? '0 : mdu.op1_i;
          end else begin
            state_d  = ST_DIV;
            cnt_d    = CW'(XLEN);
            div_load = 1'b1;
          end
        end
      end
      ST_MUL: begin
        acc_d    = mul_acc_nxt;
        mcand_d  = mcand_q << MUL_STEP;
        mplier_d = mplier_q >> MUL_STEP;
        cnt_d    = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
          wen_d   = 1'b1;
          waddr_d = rd_q;
          wdata_d = mul_res;
        end
      end
      ST_DIV: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
          wen_d   = 1'b1;
          waddr_d = rd_q;
          wdata_d = div_res;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (mdu.flush_i) begin
      state_d = ST_IDLE;
      wen_d   = 1'b0;
      waddr_d = '0;
      wdata_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      mcand_q   <= '0;
      acc_q     <= '0;
      mplier_q  <= '0;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      mplier_q  <= mplier_d;
      wen_q     <= wen_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
  end

  // A kill arriving in the write-back cycle must still cancel the strobe
  assign mdu.reg_wen_o   = wen_q & ~mdu.flush_i;
  assign mdu.rd_addr_o   = waddr_q;
  assign mdu.rd_data_o   = wdata_q;
  assign mdu.hold_flag_o = ((state_q == ST_IDLE) & accept)
                           | (state_q == ST_MUL) | (state_q == ST_DIV);

endmodule
